// File: rtl/noise_histogram.sv
// Amplitude histogram of signed noise samples over a fixed window, streamed out bin-by-bin over valid/ready.
// Optional NOISE_HIST_MOMENTS_EN adds sum_out, the exact signed sum of the window's samples.
module noise_histogram #(
  parameter int SAMPLE_BITS = 15,
  parameter int BIN_BITS    = 6,
  parameter int COUNT_BITS  = 16,
  parameter int WINDOW_LEN  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   busy,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [BIN_BITS-1:0]    rd_bin,
  output logic [COUNT_BITS-1:0]  rd_count,
  output logic                   rd_last,
`ifdef NOISE_HIST_MOMENTS_EN
  output logic signed [SAMPLE_BITS+$clog2(WINDOW_LEN)-1:0] sum_out,
`endif
  output logic                   overflow
);

  localparam int BINS  = 2**BIN_BITS;
  localparam int CNT_W = $clog2(WINDOW_LEN+1);
  localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(WINDOW_LEN-1);
  localparam logic [BIN_BITS-1:0]   LAST_BIN = BIN_BITS'(BINS-1);
  localparam logic [COUNT_BITS-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_READOUT} state_t;

  state_t state, state_nxt;

  logic [COUNT_BITS-1:0] mem [BINS];
  logic [COUNT_BITS-1:0] ram_q;
  logic [BIN_BITS-1:0]   bin_ptr;
  logic [CNT_W-1:0]      samp_cnt;
  logic                  drain_ph;
  logic                  ovf;

  logic                  s1_vld, s2_vld;
  logic [BIN_BITS-1:0]   s1_bin, s2_bin;
  logic [COUNT_BITS-1:0] s2_val;

  logic [SAMPLE_BITS-1:0] offset;
  logic [BIN_BITS-1:0]    bin_in;
  logic                   sample_hs, rd_hs, window_done;
  logic [COUNT_BITS-1:0]  cur_val, upd_val;
  logic                   sat_hit;
  logic                   we;
  logic [BIN_BITS-1:0]    waddr, raddr;
  logic [COUNT_BITS-1:0]  wdat;
  logic                   unused_low_bits;

  // Offset binary: most negative sample lands in bin 0, most positive in the top bin.
  assign offset          = {~sample_in[SAMPLE_BITS-1], sample_in[SAMPLE_BITS-2:0]};
  assign bin_in          = offset[SAMPLE_BITS-1 -: BIN_BITS];
  assign unused_low_bits = ^offset[SAMPLE_BITS-BIN_BITS-1:0];

  assign sample_ready = (state == S_ACCUM);
  assign busy         = (state != S_IDLE);
  assign rd_valid     = (state == S_READOUT);
  assign rd_bin       = rd_valid ? bin_ptr : '0;
  assign rd_count     = rd_valid ? ram_q : '0;
  assign rd_last      = rd_valid && (bin_ptr == LAST_BIN);
  assign overflow     = ovf;

  assign sample_hs   = sample_valid && sample_ready;
  assign rd_hs       = rd_valid && rd_ready;
  assign window_done = sample_hs && (samp_cnt == WIN_LAST);

  // The previous update is written in the same cycle this bin was read, so take it from stage 2.
  assign cur_val = (s2_vld && (s2_bin == s1_bin)) ? s2_val : ram_q;
  assign sat_hit = (cur_val == CNT_MAX);
  assign upd_val = sat_hit ? cur_val : cur_val + 1'b1;

  always_comb begin
    we    = 1'b0;
    waddr = s1_bin;
    wdat  = upd_val;
    if (s1_vld) begin
      we = 1'b1;
    end else if (state == S_CLEAR || rd_hs) begin
      we    = 1'b1;
      waddr = bin_ptr;
      wdat  = '0;
    end
  end

  // Readout keeps the next bin prefetched; the second DRAIN cycle fetches bin 0.
  always_comb begin
    raddr = bin_ptr;
    if (state == S_ACCUM) raddr = bin_in;
    else if (rd_hs)       raddr = bin_ptr + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:   if (bin_ptr == LAST_BIN) state_nxt = S_IDLE;
      S_IDLE:    if (start) state_nxt = S_ACCUM;
      S_ACCUM:   if (window_done) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_ph) state_nxt = S_READOUT;
      S_READOUT: if (rd_hs && rd_last) state_nxt = S_IDLE;
      default:   state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_ptr  <= '0;
      samp_cnt <= '0;
      drain_ph <= 1'b0;
      ovf      <= 1'b0;
      s1_vld   <= 1'b0;
      s1_bin   <= '0;
      s2_vld   <= 1'b0;
      s2_bin   <= '0;
      s2_val   <= '0;
      ram_q    <= '0;
    end else begin
      if (state == S_CLEAR || rd_hs) bin_ptr <= bin_ptr + 1'b1;
      drain_ph <= (state == S_DRAIN) && !drain_ph;
      if (state == S_IDLE && start) begin
        samp_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        if (sample_hs) samp_cnt <= samp_cnt + 1'b1;
        if (s1_vld && sat_hit) ovf <= 1'b1;
      end
      s1_vld <= sample_hs;
      s1_bin <= bin_in;
      s2_vld <= s1_vld;
      s2_bin <= s1_bin;
      s2_val <= upd_val;
      ram_q  <= mem[raddr];
    end
  end

`ifdef NOISE_HIST_MOMENTS_EN
  localparam int SUM_W = SAMPLE_BITS + $clog2(WINDOW_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sum_out <= '0;
    else if (state == S_IDLE && start) sum_out <= '0;
    else if (sample_hs)
      sum_out <= sum_out + $signed({{(SUM_W-SAMPLE_BITS){sample_in[SAMPLE_BITS-1]}}, sample_in});
  end
`endif

endmodule

// File: tb/tb_noise_histogram.sv
// Directed bench: two instances (16-bit and 8-bit counters) share stimulus; expected bins come from a bench-side model.
module tb_noise_histogram;

  logic        clk = 1'b0;
  logic        rst_n, start, sample_valid, rd_ready;
  logic [14:0] sample_in;

  logic        a_sample_ready, a_busy, a_rd_valid, a_rd_last, a_overflow;
  logic [5:0]  a_rd_bin;
  logic [15:0] a_rd_count;
  logic        b_sample_ready, b_busy, b_rd_valid, b_rd_last, b_overflow;
  logic [5:0]  b_rd_bin;
  logic [7:0]  b_rd_count;
`ifdef NOISE_HIST_MOMENTS_EN
  logic signed [26:0] a_sum, b_sum;
`endif

  int     errors = 0;
  int     checks = 0;
  int     exp_a [64];
  longint exp_sum;

  always #5 clk = ~clk;

  noise_histogram dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(a_sample_ready), .busy(a_busy),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_bin(a_rd_bin),
    .rd_count(a_rd_count), .rd_last(a_rd_last),
`ifdef NOISE_HIST_MOMENTS_EN
    .sum_out(a_sum),
`endif
    .overflow(a_overflow)
  );

  noise_histogram #(.COUNT_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(b_sample_ready), .busy(b_busy),
    .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_bin(b_rd_bin),
    .rd_count(b_rd_count), .rd_last(b_rd_last),
`ifdef NOISE_HIST_MOMENTS_EN
    .sum_out(b_sum),
`endif
    .overflow(b_overflow)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gen(input int mode, input int i);
    case (mode)
      0:       return 0;
      1:       return (i % 2 == 0) ? -16384 : 16383;
      2:       return 5;
      3:       return 256;
      4:       return (i % 64) * 512 - 16384;
      5:       return -1;
      6:       return 3;
      default: return -2;
    endcase
  endfunction

  function automatic int bin_of(input int s);
    return (s + 16384) / 512;
  endfunction

  task automatic check_reset;
    chk("rst_ready", a_sample_ready, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_rd_last", a_rd_last, 0);
    chk("rst_ovf_a", a_overflow, 0);
    chk("rst_ovf_b", b_overflow, 0);
    chk("rst_rd_bin", a_rd_bin, 0);
    chk("rst_rd_count", a_rd_count, 0);
    chk("rst_busy", a_busy, 1);
`ifdef NOISE_HIST_MOMENTS_EN
    chk("rst_sum", a_sum, 0);
`endif
  endtask

  task automatic check_clear;
    int n = 0;
    bit quiet = 1'b1;
    while (a_busy === 1'b1 && n < 200) begin
      if (a_sample_ready !== 1'b0 || a_rd_valid !== 1'b0) quiet = 1'b0;
      n++;
      step;
    end
    chk("clear_len", n, 64);
    chk("clear_quiet", quiet, 1);
  endtask

  task automatic run_window(input int mode, input int stall_bin);
    int          s;
    logic [31:0] v;
    int          exp_b;
    bit          any_sat = 1'b0;
    for (int b = 0; b < 64; b++) exp_a[b] = 0;
    exp_sum = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("start_ready", a_sample_ready, 1);
    for (int i = 0; i < 4096; i++) begin
      s = gen(mode, i);
      v = s;
      sample_in = v[14:0];
      sample_valid = 1'b1;
      exp_a[bin_of(s)]++;
      exp_sum += s;
      step;
    end
    sample_valid = 1'b0;
    sample_in = '0;
    chk("ready_drop", a_sample_ready, 0);
    chk("drain_busy", a_busy, 1);
    chk("drain_vld1", a_rd_valid, 0);
    step;
    chk("drain_vld2", a_rd_valid, 0);
    step;
    chk("first_vld_a", a_rd_valid, 1);
    chk("first_vld_b", b_rd_valid, 1);
    for (int b = 0; b < 64; b++) if (exp_a[b] > 255) any_sat = 1'b1;
    chk("ovf_a", a_overflow, 0);
    chk("ovf_b", b_overflow, any_sat);
`ifdef NOISE_HIST_MOMENTS_EN
    chk("sum_a", a_sum, exp_sum);
    chk("sum_b", b_sum, exp_sum);
`endif
    rd_ready = 1'b1;
    for (int bi = 0; bi < 64; bi++) begin
      if (bi == stall_bin) begin
        rd_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          step;
          chk($sformatf("stall_%0d", k), {a_rd_valid, a_rd_bin, a_rd_count, a_rd_last},
              {1'b1, 6'(stall_bin), 16'(exp_a[stall_bin]), 1'b0});
        end
        rd_ready = 1'b1;
      end
      exp_b = (exp_a[bi] > 255) ? 255 : exp_a[bi];
      chk($sformatf("vld[%0d]", bi), a_rd_valid, 1);
      chk($sformatf("bin[%0d]", bi), a_rd_bin, bi);
      chk($sformatf("cnt_a[%0d]", bi), a_rd_count, exp_a[bi]);
      chk($sformatf("cnt_b[%0d]", bi), b_rd_count, exp_b);
      chk($sformatf("last[%0d]", bi), a_rd_last, bi == 63);
      step;
    end
    chk("end_busy", a_busy, 0);
    chk("end_rd_valid", a_rd_valid, 0);
    chk("end_rd_last", a_rd_last, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    rd_ready = 1'b0;
    step;
    step;
    check_reset;
    rst_n = 1'b1;
    check_clear;
    step;

    run_window(0, -1);
    run_window(1, -1);
    run_window(2, -1);
    run_window(3, -1);
    run_window(4, 20);
`ifdef NOISE_HIST_MOMENTS_EN
    run_window(6, -1);
    run_window(7, -1);
`endif

    // Abort a window part-way through accumulation.
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample_in = 15'd0;
      sample_valid = 1'b1;
      step;
    end
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check_reset;
    step;
    rst_n = 1'b1;
    check_clear;
    step;
    run_window(5, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
